mmio_bus_fabric: RTL



---
 rtl/mmio_bus_pkg.sv | 33 +++
 rtl/mmio_region_decoder.sv | 49 ++++
 rtl/mmio_bus_fabric.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_pkg.sv
// -----------------------------------------------------------------------------
// mmio_bus_pkg
// Shared types, constants and helpers for the MMIO bus fabric and its region
// decoder.
//   state_e  : access FSM states (idle, access in progress, completion)
//   WAIT_W   : width of one per-region wait-state field
//   slot()   : extracts field i of width w from a packed parameter vector;
//              field 0 is the least significant (rightmost) one
// -----------------------------------------------------------------------------
package mmio_bus_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } state_e;

   localparam int unsigned WAIT_W     = 4;

   // Widest packed vector and widest field slot() has to handle.
   localparam int unsigned SLOT_VEC_W = 512;
   localparam int unsigned SLOT_W     = 32;

   function automatic logic [SLOT_W-1:0] slot(input logic [SLOT_VEC_W-1:0] vec,
                                              input int unsigned           i,
                                              input int unsigned           w);
      logic [SLOT_W-1:0] mask;
      mask = '1;
      mask = mask >> (SLOT_W - w);
      return SLOT_W'(vec >> (i * w)) & mask;
   endfunction

endpackage

// File: rtl/mmio_region_decoder.sv
// -----------------------------------------------------------------------------
// mmio_region_decoder
// Combinational priority decode of a word address against NSLAVE inclusive
// [BASE, LIMIT] windows. Where windows overlap, the lowest index wins.
// Shared with other bus masters (e.g. a future DMA engine).
// Ports:
//   i_wadr   : word address to decode (AW bits)
//   o_hit    : address falls inside some region
//   o_idx    : index of the winning region (0 when no hit)
//   o_offset : i_wadr minus the winning region's base (0 when no hit)
// -----------------------------------------------------------------------------
module mmio_region_decoder
   import mmio_bus_pkg::*;
#(
   parameter int unsigned              NSLAVE    = 4,
   parameter int unsigned              AW        = 12,
   parameter logic [NSLAVE*AW-1:0]     BASE_VEC  = {12'hB01, 12'hB00, 12'h650, 12'h000},
   parameter logic [NSLAVE*AW-1:0]     LIMIT_VEC = {12'hB01, 12'hB00, 12'hAFF, 12'h03F},
   localparam int unsigned             IDXW      = (NSLAVE > 1) ? $clog2(NSLAVE) : 1
) (
   input  logic [AW-1:0]   i_wadr,
   output logic            o_hit,
   output logic [IDXW-1:0] o_idx,
   output logic [AW-1:0]   o_offset
);

   logic [AW-1:0] w_base  [NSLAVE];
   logic [AW-1:0] w_limit [NSLAVE];

   for (genvar g = 0; g < NSLAVE; g++) begin : g_tab
      assign w_base[g]  = AW'(slot(SLOT_VEC_W'(BASE_VEC), g, AW));
      assign w_limit[g] = AW'(slot(SLOT_VEC_W'(LIMIT_VEC), g, AW));
   end

   // Scan from the top down so the lowest matching index is written last.
   always_comb begin
      o_hit    = 1'b0;
      o_idx    = '0;
      o_offset = '0;
      for (int i = int'(NSLAVE) - 1; i >= 0; i--) begin
         if ((i_wadr >= w_base[i]) && (i_wadr <= w_limit[i])) begin
            o_hit    = 1'b1;
            o_idx    = IDXW'(i);
            o_offset = i_wadr - w_base[i];
         end
      end
   end

endmodule

// File: rtl/mmio_bus_fabric.sv
// -----------------------------------------------------------------------------
// mmio_bus_fabric
// Memory-mapped interconnect between the CPU data port and NSLAVE peripheral
// regions. Each access is decoded once, latched, and then run through a small
// FSM (idle -> access -> done) with per-region wait states. Unmapped accesses
// skip straight to done: reads return 0, writes are dropped.
// Optional feature (macro MMIO_BUSERR_EN): adds err_flag / err_adr, which hold
// the byte address of the first unmapped access until reset.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cpu_adr               : CPU byte address; only bits [AW+1:2] are decoded
//   cpu_re / cpu_we       : requests, held by the CPU until cpu_ready
//   cpu_wdata             : CPU write data
//   cpu_rdata             : registered read data, valid with cpu_ready
//   cpu_ready             : one-cycle completion pulse
//   slv_sel               : one-hot region select, held through the access
//   slv_we                : one-cycle write strobe to the selected region
//   slv_adr               : word offset inside the selected region
//   slv_wdata             : latched write data, broadcast to all regions
//   slv_rdata             : packed read data, region i at [i*DW +: DW]
//   err_flag / err_adr    : (MMIO_BUSERR_EN only) sticky unmapped-access info
// -----------------------------------------------------------------------------
module mmio_bus_fabric
   import mmio_bus_pkg::*;
#(
   parameter int unsigned               NSLAVE    = 4,
   parameter int unsigned               AW        = 12,
   parameter int unsigned               DW        = 32,
   // Field 0 is the rightmost one: region0 = 0x000..0x03F, region1 = 0x650..0xAFF.
   parameter logic [NSLAVE*AW-1:0]      BASE_VEC  = {12'hB01, 12'hB00, 12'h650, 12'h000},
   parameter logic [NSLAVE*AW-1:0]      LIMIT_VEC = {12'hB01, 12'hB00, 12'hAFF, 12'h03F},
   parameter logic [NSLAVE*WAIT_W-1:0]  WAIT_VEC  = {4'd0, 4'd0, 4'd1, 4'd0}
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          cpu_adr,
   input  logic                 cpu_re,
   input  logic                 cpu_we,
   input  logic [DW-1:0]        cpu_wdata,
   output logic [DW-1:0]        cpu_rdata,
   output logic                 cpu_ready,
   output logic [NSLAVE-1:0]    slv_sel,
   output logic [NSLAVE-1:0]    slv_we,
   output logic [AW-1:0]        slv_adr,
   output logic [DW-1:0]        slv_wdata,
   input  logic [NSLAVE*DW-1:0] slv_rdata
`ifdef MMIO_BUSERR_EN
   ,
   output logic                 err_flag,
   output logic [31:0]          err_adr
`endif
);

   localparam int unsigned IDXW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

   state_e              r_state;
   state_e              w_state_d;

   logic                r_we;
   logic                r_hit;
   logic [IDXW-1:0]     r_idx;
   logic [WAIT_W-1:0]   r_cnt;
   logic [NSLAVE-1:0]   r_sel;
   logic [AW-1:0]       r_adr;
   logic [DW-1:0]       r_wdata;
   logic [DW-1:0]       r_rdata;

   logic                w_req;
   logic [AW-1:0]       w_wadr;
   logic                w_hit;
   logic [IDXW-1:0]     w_idx;
   logic [AW-1:0]       w_off;
   logic [WAIT_W-1:0]   w_wait;
   logic [NSLAVE-1:0]   w_onehot;
   logic [DW-1:0]       w_rdata_sel;
   logic                w_last;
   logic [WAIT_W-1:0]   w_wait_tab [NSLAVE];

   assign w_req  = cpu_re | cpu_we;
   assign w_wadr = cpu_adr[AW+1:2];
   // Last wait cycle of an access: strobe/capture happen here.
   assign w_last = (r_state == StAccess) && (r_cnt == '0);

   mmio_region_decoder #(
      .NSLAVE    (NSLAVE),
      .AW        (AW),
      .BASE_VEC  (BASE_VEC),
      .LIMIT_VEC (LIMIT_VEC)
   ) u_decoder (
      .i_wadr   (w_wadr),
      .o_hit    (w_hit),
      .o_idx    (w_idx),
      .o_offset (w_off)
   );

   for (genvar g = 0; g < NSLAVE; g++) begin : g_wait
      assign w_wait_tab[g] = WAIT_W'(slot(SLOT_VEC_W'(WAIT_VEC), g, WAIT_W));
   end

   // Wait count, one-hot select for the region being requested now, and read
   // data of the region latched for the current access.
   always_comb begin
      w_wait      = '0;
      w_onehot    = '0;
      w_rdata_sel = '0;
      for (int i = 0; i < int'(NSLAVE); i++) begin
         if (w_idx == IDXW'(i)) begin
            w_wait      = w_wait_tab[i];
            w_onehot[i] = w_hit;
         end
         if (r_idx == IDXW'(i)) begin
            w_rdata_sel = slv_rdata[i*DW +: DW];
         end
      end
   end

   // Next state and the combinational write strobe.
   always_comb begin
      w_state_d = r_state;
      slv_we    = '0;
      unique case (r_state)
         StIdle: begin
            if (w_req) begin
               w_state_d = w_hit ? StAccess : StDone;
            end
         end
         StAccess: begin
            if (r_cnt == '0) begin
               w_state_d = StDone;
               // Reset in the same cycle must not let a write reach the slave.
               if (r_we && !reset) begin
                  slv_we = r_sel;
               end
            end
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_hit   <= 1'b0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_adr   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if ((r_state == StIdle) && w_req) begin
            r_we    <= cpu_we;
            r_hit   <= w_hit;
            r_idx   <= w_idx;
            r_cnt   <= w_hit ? w_wait : '0;
            r_sel   <= w_onehot;
            r_adr   <= w_off;
            r_wdata <= cpu_wdata;
            // Unmapped read completes immediately with zero data.
            if (!w_hit && !cpu_we) begin
               r_rdata <= '0;
            end
         end
         if (r_state == StAccess) begin
            if (w_last) begin
               r_sel <= '0;
               if (!r_we) begin
                  r_rdata <= w_rdata_sel;
               end
            end else begin
               r_cnt <= r_cnt - WAIT_W'(1);
            end
         end
      end
   end

   assign cpu_ready = (r_state == StDone);
   assign cpu_rdata = r_rdata;
   assign slv_sel   = r_sel;
   assign slv_adr   = r_adr;
   assign slv_wdata = r_wdata;

`ifdef MMIO_BUSERR_EN
   logic        r_err_flag;
   logic [31:0] r_err_adr;
   logic [31:0] r_req_adr;

   // Only the first unmapped access is recorded; later ones are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_flag <= 1'b0;
         r_err_adr  <= '0;
         r_req_adr  <= '0;
      end else begin
         if ((r_state == StIdle) && w_req) begin
            r_req_adr <= cpu_adr;
         end
         if ((r_state == StDone) && !r_hit && !r_err_flag) begin
            r_err_flag <= 1'b1;
            r_err_adr  <= r_req_adr;
         end
      end
   end

   assign err_flag = r_err_flag;
   assign err_adr  = r_err_adr;
`else
   // Upper address bits alias by design; r_hit only matters for error capture.
   logic w_unused_bits;
   assign w_unused_bits = ^{cpu_adr[31:AW+2], cpu_adr[1:0], r_hit};
`endif

endmodule
